// File: rtl/fp_div_pkg.sv
// Shared constants and constant functions for the fp_div clock-synthesizer family.
// Used by fp_div_nco; the ppm report helper is shared with the fixed fp_div.
package fp_div_pkg;

  localparam logic WR_SEL_INC   = 1'b0;
  localparam logic WR_SEL_PHASE = 1'b1;

  // Rounded increment: round(out_hz * 2^acc_w / in_hz), 128-bit intermediate so acc_w=48 cannot overflow.
  function automatic longint unsigned fp_div_calc_inc(input longint unsigned in_hz,
                                                      input longint unsigned out_hz,
                                                      input int acc_w);
    logic [127:0] num;
    logic [127:0] quo;
    num = ({64'd0, out_hz} << acc_w) + {64'd0, in_hz >> 1};
    quo = num / {64'd0, in_hz};
    return quo[63:0];
  endfunction

  // Frequency error of a programmed increment in ppm; worst-case period jitter is one in_hz period.
  function automatic longint fp_div_ppm_err(input longint unsigned in_hz,
                                            input longint unsigned out_hz,
                                            input int acc_w,
                                            input longint unsigned inc);
    logic signed [127:0] actual_uhz;
    logic signed [127:0] target_uhz;
    logic signed [127:0] ppm;
    actual_uhz = signed'(({64'd0, in_hz} * {64'd0, inc} * 128'd1000000) >> acc_w);
    target_uhz = signed'({64'd0, out_hz} * 128'd1000000);
    ppm = ((actual_uhz - target_uhz) * 128'sd1000000) / target_uhz;
    return ppm[63:0];
  endfunction

endpackage

// File: rtl/fp_div_nco_if.sv
// Register-write bus for fp_div_nco.
// Handshake: wr_ena is a valid with an implied always-ready; every beat is consumed the cycle it is
// presented, and a rejected beat is answered by a one-cycle wr_err pulse on the following cycle.
interface fp_div_nco_if #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 32
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             wr_ena;
  logic [CH_W-1:0]  wr_chan;
  logic             wr_sel;
  logic [ACC_W-1:0] wr_data;
  logic             wr_err;

  modport master (output wr_ena, wr_chan, wr_sel, wr_data, input  wr_err);
  modport slave  (input  wr_ena, wr_chan, wr_sel, wr_data, output wr_err);
endinterface

// File: rtl/fp_div_nco_chan.sv
// One NCO channel: phase accumulator, live/shadow increment, phase offset and registered strobes.
module fp_div_nco_chan #(
  parameter int               ACC_W       = 32,
  parameter logic [ACC_W-1:0] DEFAULT_INC = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sync,
  input  logic             wr_inc,
  input  logic             wr_phase,
  input  logic [ACC_W-1:0] wr_data,
  output logic             pend,
  output logic             clk_out,
  output logic             p0,
  output logic             p180
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W-1:0] phase;
  logic [ACC_W:0]   nxt;
  logic             apply;

  assign nxt = {1'b0, acc} + {1'b0, inc};
  // A running channel only swaps increments on the wrap edge, so the current period always completes.
  assign apply = pend && (sync || !ena || nxt[ACC_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      inc     <= DEFAULT_INC;
      shadow  <= DEFAULT_INC;
      phase   <= '0;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      p0      <= 1'b0;
      p180    <= 1'b0;
    end else begin
      p0   <= 1'b0;
      p180 <= 1'b0;
      if (sync) begin
        acc     <= phase;
        clk_out <= phase[ACC_W-1];
      end else if (ena) begin
        acc     <= nxt[ACC_W-1:0];
        clk_out <= nxt[ACC_W-1];
        p0      <= nxt[ACC_W-1] & ~acc[ACC_W-1] & ~nxt[ACC_W];
        p180    <= nxt[ACC_W];
      end
      if (apply) inc <= shadow;
      // A write racing an apply keeps the new value pending for the next opportunity.
      if (wr_inc) begin
        shadow <= wr_data;
        pend   <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
      if (wr_phase) phase <= wr_data;
    end
  end

endmodule

// File: rtl/fp_div_nco.sv
// Multi-channel NCO clock synthesizer: write decode, range check and sync fan-out around
// CHANNELS independent fp_div_nco_chan instances.
module fp_div_nco
  import fp_div_pkg::*;
#(
  parameter int              CHANNELS     = 4,
  parameter int              ACC_W        = 32,
  parameter longint unsigned INPUT_CLK_HZ = 100000000,
  parameter longint unsigned RESET_OUT_HZ = 3579545
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [CHANNELS-1:0] ch_ena,
  input  logic                sync_in,
  fp_div_nco_if.slave         wr_bus,
  output logic [CHANNELS-1:0] pend,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] clk_p0,
  output logic [CHANNELS-1:0] clk_p180
);

  localparam longint unsigned DEFAULT_INC_FULL = fp_div_calc_inc(INPUT_CLK_HZ, RESET_OUT_HZ, ACC_W);
  localparam logic [ACC_W-1:0] DEFAULT_INC     = DEFAULT_INC_FULL[ACC_W-1:0];

  if (DEFAULT_INC_FULL == 64'd0 || DEFAULT_INC_FULL >= (64'd1 << (ACC_W - 1))) begin : g_bad_default
    $error("fp_div_nco: reset increment out of range 1..2^(ACC_W-1)-1");
  end

  logic                bad_data;
  logic                bad_chan;
  logic                wr_ok;
  logic [CHANNELS-1:0] sel_inc;
  logic [CHANNELS-1:0] sel_phase;

  // Increments at or above half scale would let p0 and p180 land in the same cycle.
  always_comb begin
    bad_data  = (wr_bus.wr_sel == WR_SEL_INC) &&
                ((wr_bus.wr_data == '0) || wr_bus.wr_data[ACC_W-1]);
    bad_chan  = 32'(wr_bus.wr_chan) >= 32'(CHANNELS);
    wr_ok     = wr_bus.wr_ena && !bad_data && !bad_chan;
    sel_inc   = '0;
    sel_phase = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sel_inc[c]   = wr_ok && (wr_bus.wr_sel == WR_SEL_INC)   && (32'(wr_bus.wr_chan) == 32'(c));
      sel_phase[c] = wr_ok && (wr_bus.wr_sel == WR_SEL_PHASE) && (32'(wr_bus.wr_chan) == 32'(c));
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) wr_bus.wr_err <= 1'b0;
    else           wr_bus.wr_err <= wr_bus.wr_ena && !wr_ok;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    fp_div_nco_chan #(
      .ACC_W       (ACC_W),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_chan (
      .clk      (clk_in),
      .rst_n    (rst_n_in),
      .ena      (ch_ena[c]),
      .sync     (sync_in),
      .wr_inc   (sel_inc[c]),
      .wr_phase (sel_phase[c]),
      .wr_data  (wr_bus.wr_data),
      .pend     (pend[c]),
      .clk_out  (clk_out[c]),
      .p0       (clk_p0[c]),
      .p180     (clk_p180[c])
    );
  end

endmodule
